// File: rtl/pds_responder.sv
// 68000-style IOB bus target: 4-word register file via DTACK and VPA/E paths, C16M domain.
// Terminations are registered off the next state so they change on the same edge as the FSM.
module pds_responder #(
    parameter logic [7:0] BASE     = 8'hFE,
    parameter logic [3:0] WAIT_CYC = 4'd2
) (
    input  logic        C16M,
    input  logic        nRES,
    input  logic [23:1] A,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        nWE,
    input  logic        nVMA,
    input  logic        E,
    input  logic [15:0] D_in,
    output logic [15:0] D_out,
    output logic        nDOE,
    output logic        nDTACK,
    output logic        nVPA,
    output logic        nBERR,
    output logic [7:0]  CYC_CNT
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_ACK,
        S_VMA,
        S_EWAIT,
        S_VHOLD,
        S_BERR,
        S_IGNORE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_commit;
    logic        w_done;

    logic        r_nas_m, r_nas_s;
    logic        r_uds_m, r_uds_s;
    logic        r_lds_m, r_lds_s;
    logic        r_vma_m, r_vma_s;
    logic        r_e_m, r_e_s, r_e_d;

    logic [23:1] r_a;
    logic        r_nwe;
    logic [15:0] r_regs [4];
    logic [15:0] r_dout;
    logic        r_ndoe, r_ndtack, r_nvpa, r_nberr;
    logic [7:0]  r_cyc_cnt;

    logic        w_in_win;
    logic        w_valid;
    logic        w_strobe;
    logic        w_e_fall;
    logic        w_rd_phase;
    logic [1:0]  w_idx;

    assign w_in_win = (r_a[23:16] == BASE);
    assign w_valid  = (r_a[15:4] == 12'h000);
    assign w_strobe = !r_uds_s || !r_lds_s;
    assign w_e_fall = r_e_d && !r_e_s;
    assign w_idx    = r_a[2:1];

    always_ff @(posedge C16M) begin
        if (!nRES) begin
            r_nas_m <= 1'b1; r_nas_s <= 1'b1;
            r_uds_m <= 1'b1; r_uds_s <= 1'b1;
            r_lds_m <= 1'b1; r_lds_s <= 1'b1;
            r_vma_m <= 1'b1; r_vma_s <= 1'b1;
            r_e_m   <= 1'b0; r_e_s   <= 1'b0; r_e_d <= 1'b0;
        end else begin
            r_nas_m <= nAS;  r_nas_s <= r_nas_m;
            r_uds_m <= nUDS; r_uds_s <= r_uds_m;
            r_lds_m <= nLDS; r_lds_s <= r_lds_m;
            r_vma_m <= nVMA; r_vma_s <= r_vma_m;
            r_e_m   <= E;    r_e_s   <= r_e_m;  r_e_d <= r_e_s;
        end
    end

    // Address and direction are only trusted while the synchronized strobe says the bus is ours.
    always_ff @(posedge C16M) begin
        if (!nRES) begin
            r_a   <= '0;
            r_nwe <= 1'b1;
        end else if (!r_nas_s) begin
            r_a   <= A;
            r_nwe <= nWE;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_commit   = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_nas_s) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (r_nas_s) begin
                    w_next = S_IDLE;
                end else if (w_strobe) begin
                    if (!w_in_win) begin
                        w_next = S_IGNORE;
                    end else if (!w_valid) begin
                        w_next = S_BERR;
                    end else if (!r_a[3]) begin
                        w_next     = S_WAIT;
                        w_cnt_next = WAIT_CYC;
                    end else begin
                        w_next = S_VMA;
                    end
                end
            end
            S_WAIT: begin
                if (r_nas_s) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next   = S_ACK;
                    w_commit = !r_nwe;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_ACK, S_VHOLD: begin
                if (r_nas_s) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            S_VMA: begin
                if (r_nas_s)       w_next = S_IDLE;
                else if (!r_vma_s) w_next = S_EWAIT;
            end
            S_EWAIT: begin
                if (r_nas_s) begin
                    w_next = S_IDLE;
                end else if (w_e_fall) begin
                    w_next   = S_VHOLD;
                    w_commit = !r_nwe;
                end
            end
            S_BERR, S_IGNORE: begin
                if (r_nas_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_rd_phase = r_nwe && ((w_next == S_WAIT) || (w_next == S_ACK) ||
                                  (w_next == S_VMA) || (w_next == S_EWAIT) ||
                                  (w_next == S_VHOLD));

    always_ff @(posedge C16M) begin
        if (!nRES) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_cyc_cnt <= 8'd0;
            r_dout    <= 16'h0000;
            r_ndoe    <= 1'b1;
            r_ndtack  <= 1'b1;
            r_nvpa    <= 1'b1;
            r_nberr   <= 1'b1;
            for (int i = 0; i < 4; i++) r_regs[i] <= 16'h0000;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_ndtack <= !(w_next == S_ACK);
            r_nvpa   <= !((w_next == S_VMA) || (w_next == S_EWAIT) || (w_next == S_VHOLD));
            r_nberr  <= !(w_next == S_BERR);
            r_ndoe   <= !w_rd_phase;
            if (w_rd_phase) r_dout <= r_regs[w_idx];
            if (w_done) r_cyc_cnt <= r_cyc_cnt + 8'd1;
            if (w_commit) begin
                if (!r_uds_s) r_regs[w_idx][15:8] <= D_in[15:8];
                if (!r_lds_s) r_regs[w_idx][7:0]  <= D_in[7:0];
            end
        end
    end

    assign D_out   = r_dout;
    assign nDOE    = r_ndoe;
    assign nDTACK  = r_ndtack;
    assign nVPA    = r_nvpa;
    assign nBERR   = r_nberr;
    assign CYC_CNT = r_cyc_cnt;

endmodule

// File: tb/tb_pds_responder.sv
// Randomized bus-master bench for pds_responder with a queue scoreboard and a bus-level model.
module tb_pds_responder;

    localparam logic [7:0] BASE = 8'hFE;
    localparam int         WC   = 2;

    logic        C16M = 1'b0;
    logic        nRES;
    logic [23:1] A;
    logic        nAS, nUDS, nLDS, nWE, nVMA, E;
    logic [15:0] D_in;
    logic [15:0] D_out;
    logic        nDOE, nDTACK, nVPA, nBERR;
    logic [7:0]  CYC_CNT;

    pds_responder #(.BASE(BASE), .WAIT_CYC(4'(WC))) dut (
        .C16M(C16M), .nRES(nRES), .A(A), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
        .nWE(nWE), .nVMA(nVMA), .E(E), .D_in(D_in), .D_out(D_out), .nDOE(nDOE),
        .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR), .CYC_CNT(CYC_CNT)
    );

    always #5 C16M = ~C16M;

    // kind: 0 = no termination, 1 = DTACK, 2 = VPA, 3 = BERR
    typedef struct {
        int          kind;
        bit          rd;
        logic [15:0] dat;
        logic [7:0]  cnt0;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] m_regs [4];
    logic [7:0]  m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [23:1] ad(input logic [23:0] byte_addr);
        return byte_addr[23:1];
    endfunction

    // Monitor: tracks one bus cycle from nAS low to nAS high, then scores it.
    bit          mon_in = 0;
    int          mon_ecnt, mon_kind, mon_lat, mon_sum;
    logic [15:0] mon_dat;
    logic        mon_doe, mon_held;
    logic [7:0]  mon_cnt0;
    bit          mon_multi;

    initial begin
        exp_t e;
        forever begin
            @(negedge C16M);
            mon_sum = (nDTACK ? 0 : 1) + (nVPA ? 0 : 1) + (nBERR ? 0 : 1);
            if (!mon_in && nAS === 1'b0) begin
                mon_in = 1; mon_ecnt = -1; mon_kind = 0; mon_lat = -1;
                mon_multi = 0; mon_cnt0 = CYC_CNT;
            end else if (mon_in && !nAS) begin
                mon_ecnt++;
                if (mon_sum > 1) mon_multi = 1;
                if (mon_kind == 0 && mon_sum != 0) begin
                    mon_kind = !nDTACK ? 1 : (!nVPA ? 2 : 3);
                    mon_lat  = mon_ecnt;
                    mon_dat  = D_out;
                    mon_doe  = nDOE;
                end
            end else if (mon_in && nAS) begin
                mon_in = 0;
                mon_held = (mon_kind == 1) ? !nDTACK : (mon_kind == 2) ? !nVPA :
                           (mon_kind == 3) ? !nBERR : 1'b0;
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_empty actual=cycle required=no_cycle");
                end else begin
                    e = q.pop_front();
                    chk("term_kind", mon_kind, e.kind);
                    chk("cnt_at_start", {24'h0, mon_cnt0}, {24'h0, e.cnt0});
                    chk("single_term", {31'h0, mon_multi}, 0);
                    if (e.kind != 0) chk("term_held", {31'h0, mon_held}, 1);
                    if (e.kind == 1) chk("dtack_latency", mon_lat, 4 + WC);
                    if (e.rd && (e.kind == 1 || e.kind == 2)) begin
                        chk("rd_data", {16'h0, mon_dat}, {16'h0, e.dat});
                        chk("rd_ndoe", {31'h0, mon_doe}, 0);
                    end
                end
            end
        end
    end

    // mode: 0 = complete cycle, 1 = abort during WAIT, 2 = reset while in EWAIT
    task automatic bus_cycle(input logic [23:1] addr, input bit wr, input logic [15:0] wd,
                             input bit uds, input bit lds, input int mode);
        exp_t       e;
        int         kind;
        int         n;
        logic [1:0] idx;
        idx = addr[2:1];
        if (addr[23:16] != BASE)    kind = 0;
        else if (addr[15:4] != 0)   kind = 3;
        else                        kind = addr[3] ? 2 : 1;
        if (mode == 1) kind = 0;
        e.kind = kind; e.rd = !wr; e.dat = m_regs[idx]; e.cnt0 = m_cnt;
        if ((kind == 1 || kind == 2) && mode == 0) begin
            if (wr && uds) m_regs[idx][15:8] = wd[15:8];
            if (wr && lds) m_regs[idx][7:0]  = wd[7:0];
            m_cnt = m_cnt + 8'd1;
        end
        q.push_back(e);

        @(posedge C16M); #2;
        A = addr; nWE = !wr; D_in = wd; nUDS = !uds; nLDS = !lds; nAS = 1'b0;
        if (mode == 1) begin
            repeat (3) @(posedge C16M);
            #2;
        end else if (kind == 0) begin
            repeat (12) @(posedge C16M);
            #2;
        end else begin
            n = 0;
            while (nDTACK && nVPA && nBERR && n < 30) begin
                @(posedge C16M); #2; n++;
            end
            if (n == 30) begin
                checks++; failures++;
                $display("FAIL term_timeout actual=none required=kind%0d", kind);
            end
            if (!nVPA) begin
                nVMA = 1'b0;
                repeat (4) @(posedge C16M);
                #2;
                if (mode == 2) begin
                    nRES = 1'b0; nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nVMA = 1'b1;
                    @(posedge C16M); #1;
                    chk("rst_ndtack", {31'h0, nDTACK}, 1);
                    chk("rst_nvpa", {31'h0, nVPA}, 1);
                    chk("rst_nberr", {31'h0, nBERR}, 1);
                    chk("rst_ndoe", {31'h0, nDOE}, 1);
                    chk("rst_dout", {16'h0, D_out}, 0);
                    chk("rst_cyc_cnt", {24'h0, CYC_CNT}, 0);
                    #1; nRES = 1'b1;
                    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
                    m_cnt = 8'd0;
                end else begin
                    E = 1'b1;
                    repeat (3) @(posedge C16M);
                    #2; E = 1'b0;
                    repeat (5) @(posedge C16M);
                    #2;
                end
            end else begin
                repeat (2) @(posedge C16M);
                #2;
            end
        end
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nVMA = 1'b1; nWE = 1'b1;
        n = 0;
        while (!(nDTACK && nVPA && nBERR) && n < 20) begin
            @(posedge C16M); #2; n++;
        end
        if (n == 20) begin
            checks++; failures++;
            $display("FAIL release_timeout actual=asserted required=released");
        end
        repeat (2) @(posedge C16M);
    endtask

    task automatic rand_cycle();
        int          r;
        logic [1:0]  lanes;
        logic [1:0]  idx;
        logic [11:0] mid;
        logic [7:0]  hi;
        logic [23:0] ba;
        bit          wr;
        int          mode;
        r     = $urandom_range(0, 9);
        lanes = 2'($urandom_range(1, 3));
        idx   = 2'($urandom_range(0, 3));
        mid   = 12'($urandom_range(1, 4095));
        hi    = BASE ^ 8'($urandom_range(1, 255));
        wr    = ($urandom_range(0, 1) == 1);
        mode  = 0;
        if (r < 5)      ba = {BASE, 12'h000, 1'b0, idx, 1'b0};
        else if (r < 8) ba = {BASE, 12'h000, 1'b1, idx, 1'b0};
        else if (r < 9) ba = {BASE, mid, 4'h0};
        else            ba = {hi, 16'h0000};
        if (r < 5 && $urandom_range(0, 7) == 0) mode = 1;
        bus_cycle(ad(ba), wr, 16'($urandom), lanes[1], lanes[0], mode);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        nRES = 1'b0; A = '0; nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nWE = 1'b1;
        nVMA = 1'b1; E = 1'b0; D_in = 16'h0000;
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
        m_cnt = 8'd0;
        repeat (3) @(posedge C16M);
        #1;
        chk("reset_ndtack", {31'h0, nDTACK}, 1);
        chk("reset_nvpa", {31'h0, nVPA}, 1);
        chk("reset_nberr", {31'h0, nBERR}, 1);
        chk("reset_ndoe", {31'h0, nDOE}, 1);
        chk("reset_dout", {16'h0, D_out}, 0);
        chk("reset_cyc_cnt", {24'h0, CYC_CNT}, 0);
        #1; nRES = 1'b1;
        repeat (2) @(posedge C16M);

        bus_cycle(ad(24'hFE0002), 1, 16'hA55A, 1, 1, 0);
        bus_cycle(ad(24'hFE0002), 0, 16'h0000, 1, 1, 0);
        bus_cycle(ad(24'hFE0000), 1, 16'h1234, 1, 1, 0);
        bus_cycle(ad(24'hFE0000), 1, 16'h003C, 0, 1, 0);
        bus_cycle(ad(24'hFE0000), 0, 16'h0000, 1, 1, 0);
        bus_cycle(ad(24'hFE0000), 1, 16'hFF00, 1, 0, 0);
        bus_cycle(ad(24'hFE0008), 0, 16'h0000, 1, 1, 0);
        bus_cycle(ad(24'hFE0010), 1, 16'hBEEF, 1, 1, 0);
        bus_cycle(ad(24'hFD0000), 1, 16'hBEEF, 1, 1, 0);
        bus_cycle(ad(24'hFE0000), 1, 16'hDEAD, 1, 1, 1);
        bus_cycle(ad(24'hFE0000), 0, 16'h0000, 1, 1, 0);
        bus_cycle(ad(24'hFE000A), 1, 16'h5A5A, 1, 1, 0);
        bus_cycle(ad(24'hFE0002), 0, 16'h0000, 1, 1, 0);
        bus_cycle(ad(24'hFE0008), 0, 16'h0000, 1, 1, 2);
        bus_cycle(ad(24'hFE0002), 0, 16'h0000, 1, 1, 0);

        for (int i = 0; i < 100; i++) rand_cycle();

        while (m_cnt != 8'hFF)
            bus_cycle(ad({BASE, 12'h000, 1'b0, 2'($urandom_range(0, 3)), 1'b0}), 0, 16'h0, 1, 1, 0);
        bus_cycle(ad(24'hFE0004), 0, 16'h0000, 1, 1, 0);
        #1;
        chk("cyc_cnt_wrap", {24'h0, CYC_CNT}, 0);
        bus_cycle(ad(24'hFE0006), 0, 16'h0000, 1, 1, 0);
        repeat (2) @(posedge C16M);
        chk("sb_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pds_responder.md
# pds_responder

Synchronous 68000-style bus target for the Mac SE PDS (IOB) side. It answers the accelerator's IOB master cycles (nAS/nUDS/nLDS/nWE/nVMA) with nDTACK, nVPA or nBERR, running in the C16M domain. It contains a 4-word byte-lane-writable register file reachable via an asynchronous (DTACK) path and a 6800-synchronous (VPA/E) path. It serves as the bring-up and loopback target for the IOB master and is synthesizable for a PDS-card CPLD.

## Interface
Parameters:
- BASE, 8'hFE, A[23:16] match value for the decode window
- WAIT_CYC, 4'd2, extra C16M wait states before nDTACK on the DTACK path

Ports:
- C16M  in  1  clock, all logic on rising edge
- nRES  in  1  reset: one clock; reset is synchronous and active-low
- A  in  23 [23:1]  bus address, stable while nAS low
- nAS, nUDS, nLDS, nWE  in  1 each  asynchronous bus strobes
- nVMA  in  1  asynchronous valid-memory-address from master
- E  in  1  asynchronous E clock
- D_in  in  16  write data from bus
- D_out  out  16  read data
- nDOE  out  1  read data output enable, active low
- nDTACK, nVPA, nBERR  out  1 each  cycle termination, active low, registered
- CYC_CNT  out  8  count of successfully completed cycles

## Operation
- nAS, nUDS, nLDS, nVMA and E pass through 2-flop synchronizers (…_s). A, nWE and D_in are sampled only while nAS_s is low.
- Decode, evaluated in DECODE:
  - A[23:16]!=BASE: out of window, no response.
  - In window with A[15:4]!=0: BERR.
  - A[3]=0: DTACK path, register A[2:1].
  - A[3]=1: VPA path, register A[2:1].
- Byte lanes: nUDS_s low selects bits [15:8]; nLDS_s low selects bits [7:0]. Writes update only the selected lanes. Reads drive all 16 bits.
- FSM states: IDLE, DECODE, WAIT, ACK, VMA, EWAIT, VHOLD, BERR, IGNORE.
  - IDLE: nAS_s=0 → DECODE.
  - DECODE: stays until nUDS_s or nLDS_s is low, which covers write strobes that lag nAS. Then:
    - out of window → IGNORE
    - invalid → BERR
    - DTACK path → WAIT, loading cnt=WAIT_CYC
    - VPA path → VMA
  - WAIT: cnt==0 → ACK; otherwise cnt−1. A write commits on the WAIT→ACK edge.
  - ACK: nDTACK=0; nAS_s=1 → IDLE.
  - VMA: nVPA=0; nVMA_s=0 → EWAIT.
  - EWAIT: nVPA=0; on E_s falling (previous 1, now 0), a write commits → VHOLD.
  - VHOLD: nVPA=0; nAS_s=1 → IDLE.
  - BERR: nBERR=0; nAS_s=1 → IDLE.
  - IGNORE: all outputs released; nAS_s=1 → IDLE.
- nDOE=0 and D_out=reg[A[2:1]] for reads (nWE=1) in WAIT, ACK, VMA, EWAIT and VHOLD. Otherwise nDOE=1 and D_out holds its last value.
- Abort: nAS_s=1 while in DECODE, WAIT, VMA or EWAIT → IDLE next edge. No write commit, no CYC_CNT increment, all outputs released.
- CYC_CNT increments on ACK→IDLE and VHOLD→IDLE only, wrapping 255→0.
- Reset (nRES=0 at an edge) is allowed at any time, including mid-cycle, and forces on that edge:
  - FSM=IDLE
  - regs=0, CYC_CNT=0, D_out=0
  - nDTACK=nVPA=nBERR=nDOE=1
  - synchronizers set to 1, E sync to 0

## Timing
- Edge 0 is the edge that first samples nAS and a strobe low.
  - nAS_s low after edge 1.
  - IDLE→DECODE at edge 2.
  - DECODE exit at edge 3.
  - nDTACK low from edge 4+WAIT_CYC, i.e. edge 6 at the default.
- nDTACK/nVPA/nBERR deassert on the edge after nAS_s is seen high, i.e. 2–3 edges after bus nAS rises.
- At most one termination output is low at any time; nDTACK and nVPA are never asserted together.
- Write data is captured from D_in at the commit edge. The master must hold D_in until termination.
- E falling that arrives while still in VMA is ignored; the FSM waits for the next fall.
- Back-to-back cycles: nAS must be sampled high for at least one edge before the next cycle starts decoding.

## Test plan
- Word write $FE0002=16'hA55A (both strobes), WAIT_CYC=2 → nDTACK low at edge 6, held until nAS high. Read-back gives D_out=16'hA55A, nDOE=0, CYC_CNT=2.
- Byte write via nLDS only, 8'h3C, to reg0 (previously 16'h1234) → reg0=16'h123C. nUDS-only write 8'hFF → 16'hFF3C.
- VPA read of $FE0008: nVPA low after DECODE, no nDTACK. Toggle nVMA low, then E 1→0 → D_out=reg0, nVPA held until nAS high, CYC_CNT +1.
- $FE0010 → nBERR low until nAS high, regs and CYC_CNT unchanged. $FD0000 → no output asserted.
- Abort: nAS rises during WAIT of a write → no nDTACK, reg unchanged, FSM IDLE. Reset pulse asserted during EWAIT → all outputs high, regs=0 on the next edge.
- 256 completed cycles → CYC_CNT wraps to 0.
